// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: syncs, active window, x/y and an
// incrementally computed address into an integer-downscaled framebuffer.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned H_POL       = 0,
  parameter int unsigned V_POL       = 0,
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pix_ce_i,
  input  logic en_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic video_en_o,
  output logic [$clog2(H_ACTIVE)-1:0] x_o,
  output logic [$clog2(V_ACTIVE)-1:0] y_o,
  output logic [$clog2((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))-1:0] fb_addr_o,
  output logic line_start_o,
  output logic frame_start_o,
  output logic running_o
);

  localparam int unsigned CW      = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_ACTIVE);
  localparam int unsigned YW      = $clog2(V_ACTIVE);
  localparam int unsigned FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FB_H    = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned AW      = $clog2(FB_W * FB_H);

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] SC_MASK = CW'((1 << SCALE_SHIFT) - 1);
  localparam logic [AW-1:0] FB_STEP = AW'(FB_W);
  localparam logic          HS_ON   = 1'(H_POL);
  localparam logic          VS_ON   = 1'(V_POL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt, h_adv, v_adv;
  logic [AW-1:0] line_base, line_base_nxt, fb_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          active_nxt, vid_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;
  logic          frame_wrap;

  // State register, advanced only on pixel steps
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       state <= ST_IDLE;
    else if (pix_ce_i) state <= state_nxt;
  end

  // Next position and every registered output derived from it
  always_comb begin
    state_nxt     = state;
    h_nxt         = h_cnt;
    v_nxt         = v_cnt;
    active_nxt    = 1'b0;
    frame_wrap    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    h_adv         = (h_cnt == H_LAST) ? '0 : h_cnt + CW'(1);
    v_adv         = v_cnt;
    if (h_cnt == H_LAST) v_adv = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);

    case (state)
      ST_IDLE: begin
        if (en_i) begin
          state_nxt  = ST_RUN;
          h_nxt      = '0;
          v_nxt      = '0;
          active_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        h_nxt      = h_adv;
        v_nxt      = v_adv;
        active_nxt = 1'b1;
        if (!en_i) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_wrap && !en_i) begin
          state_nxt = ST_IDLE;
          h_nxt     = '0;
          v_nxt     = '0;
        end else begin
          h_nxt      = h_adv;
          v_nxt      = v_adv;
          active_nxt = 1'b1;
          if (en_i) state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    endcase

    vid_nxt = active_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt  = (active_nxt && (h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_ON : ~HS_ON;
    vs_nxt  = (active_nxt && (v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_ON : ~VS_ON;
    ls_nxt  = active_nxt && (h_nxt == '0);
    fs_nxt  = ls_nxt && (v_nxt == '0);
    x_nxt   = vid_nxt ? XW'(h_nxt) : '0;
    y_nxt   = vid_nxt ? YW'(v_nxt) : '0;

    // Row base steps by one framebuffer row after each block of scaled lines
    line_base_nxt = line_base;
    if (ls_nxt) begin
      if (v_nxt == '0)
        line_base_nxt = '0;
      else if ((v_nxt < V_ACT) && ((v_nxt & SC_MASK) == '0))
        line_base_nxt = line_base + FB_STEP;
    end

    fb_nxt = fb_addr_o;
    if (vid_nxt) begin
      if (h_nxt == '0)                   fb_nxt = line_base_nxt;
      else if ((h_nxt & SC_MASK) == '0)  fb_nxt = fb_addr_o + AW'(1);
    end
  end

  // Counters and outputs, all held while pix_ce_i is low
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      line_base     <= '0;
      fb_addr_o     <= '0;
      x_o           <= '0;
      y_o           <= '0;
      video_en_o    <= 1'b0;
      hsync_o       <= ~HS_ON;
      vsync_o       <= ~VS_ON;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      running_o     <= 1'b0;
    end else if (pix_ce_i) begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      line_base     <= line_base_nxt;
      fb_addr_o     <= fb_nxt;
      x_o           <= x_nxt;
      y_o           <= y_nxt;
      video_en_o    <= vid_nxt;
      hsync_o       <= hs_nxt;
      vsync_o       <= vs_nxt;
      line_start_o  <= ls_nxt;
      frame_start_o <= fs_nxt;
      running_o     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny
// active-high-sync configuration for full-frame, stall, drain and reset cases.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default timing
  logic        rst_a, ce_a, en_a;
  logic        a_hs, a_vs, a_vid, a_ls, a_fs, a_run;
  logic [9:0]  a_x;
  logic [8:0]  a_y;
  logic [16:0] a_fb;

  // Instance B: H 8/2/2/2, V 4/1/1/1, active-high syncs, SCALE_SHIFT=1
  logic        rst_b, ce_b, en_b;
  logic        b_hs, b_vs, b_vid, b_ls, b_fs, b_run;
  logic [2:0]  b_x;
  logic [1:0]  b_y;
  logic [2:0]  b_fb;

  video_timing_gen u_a (
    .clk_i(clk), .reset_i(rst_a), .pix_ce_i(ce_a), .en_i(en_a),
    .hsync_o(a_hs), .vsync_o(a_vs), .video_en_o(a_vid), .x_o(a_x), .y_o(a_y),
    .fb_addr_o(a_fb), .line_start_o(a_ls), .frame_start_o(a_fs), .running_o(a_run)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .SCALE_SHIFT(1)
  ) u_b (
    .clk_i(clk), .reset_i(rst_b), .pix_ce_i(ce_b), .en_i(en_b),
    .hsync_o(b_hs), .vsync_o(b_vs), .video_en_o(b_vid), .x_o(b_x), .y_o(b_y),
    .fb_addr_o(b_fb), .line_start_o(b_ls), .frame_start_o(b_fs), .running_o(b_run)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference for instance B: 0 idle, 1 run, 2 drain; position being presented
  int m_st, mh, mv, mfb;

  task automatic model_adv();
    if (mh == 13) begin
      mh = 0;
      mv = (mv == 6) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic model_step(input logic en);
    case (m_st)
      0: if (en) begin m_st = 1; mh = 0; mv = 0; end
      1: begin model_adv(); if (!en) m_st = 2; end
      default: begin
        if (mh == 13 && mv == 6 && !en) begin
          m_st = 0; mh = 0; mv = 0;
        end else begin
          model_adv();
          if (en) m_st = 1;
        end
      end
    endcase
    if (m_st != 0 && mh < 8 && mv < 4) mfb = (mv / 2) * 4 + mh / 2;
  endtask

  task automatic check_b(input string tag);
    logic act, vid;
    string p;
    act = (m_st != 0);
    vid = act && mh < 8 && mv < 4;
    p = $sformatf("%s h%0d v%0d", tag, mh, mv);
    chk({p, " hsync"}, 32'(b_hs), (act && mh >= 10 && mh < 12) ? 1 : 0);
    chk({p, " vsync"}, 32'(b_vs), (act && mv == 5) ? 1 : 0);
    chk({p, " video_en"}, 32'(b_vid), 32'(vid));
    chk({p, " x"}, 32'(b_x), vid ? mh : 0);
    chk({p, " y"}, 32'(b_y), vid ? mv : 0);
    chk({p, " fb_addr"}, 32'(b_fb), mfb);
    chk({p, " line_start"}, 32'(b_ls), (act && mh == 0) ? 1 : 0);
    chk({p, " frame_start"}, 32'(b_fs), (act && mh == 0 && mv == 0) ? 1 : 0);
    chk({p, " running"}, 32'(b_run), 32'(act));
  endtask

  task automatic cyc_b(input string tag, input logic ce, input logic en);
    ce_b = ce;
    en_b = en;
    @(posedge clk);
    #1;
    if (ce) model_step(en);
    check_b(tag);
  endtask

  initial begin
    int h, v, hs_low;
    rst_a = 1'b1; ce_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; ce_b = 1'b0; en_b = 1'b0;
    m_st = 0; mh = 0; mv = 0; mfb = 0;
    #22;

    // ---- Instance A: reset levels (active-low syncs idle high)
    chk("a_rst hsync", 32'(a_hs), 1);
    chk("a_rst vsync", 32'(a_vs), 1);
    chk("a_rst video_en", 32'(a_vid), 0);
    chk("a_rst fb_addr", 32'(a_fb), 0);
    chk("a_rst running", 32'(a_run), 0);
    chk("a_rst frame_start", 32'(a_fs), 0);
    rst_a = 1'b0;

    // ---- Instance A: free run across three lines, step i presents (i%800, i/800)
    hs_low = 0;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #1;
      h = i % 800;
      v = i / 800;
      chk($sformatf("a_hsync h%0d v%0d", h, v), 32'(a_hs), (h >= 656 && h < 752) ? 0 : 1);
      chk($sformatf("a_frame_start h%0d v%0d", h, v), 32'(a_fs), (i == 0) ? 1 : 0);
      if (v == 0 && !a_hs) hs_low++;
      if (h == 0 && v == 0) begin
        chk("a_fb(0,0)", 32'(a_fb), 0);
        chk("a_video(0,0)", 32'(a_vid), 1);
        chk("a_running", 32'(a_run), 1);
      end
      if (h == 1 && v == 0)   chk("a_fb(1,0)", 32'(a_fb), 0);
      if (h == 2 && v == 0)   chk("a_fb(2,0)", 32'(a_fb), 1);
      if (h == 639 && v == 0) begin
        chk("a_fb(639,0)", 32'(a_fb), 319);
        chk("a_x(639,0)", 32'(a_x), 639);
      end
      if (h == 640 && v == 0) chk("a_video(640,0)", 32'(a_vid), 0);
      if (h == 700 && v == 0) begin
        chk("a_fb hold(700,0)", 32'(a_fb), 319);
        chk("a_x blank(700,0)", 32'(a_x), 0);
      end
      if (h == 0 && v == 1) begin
        chk("a_fb(0,1)", 32'(a_fb), 0);
        chk("a_line_start(0,1)", 32'(a_ls), 1);
        chk("a_y(0,1)", 32'(a_y), 1);
      end
      if (h == 0 && v == 2)   chk("a_fb(0,2)", 32'(a_fb), 320);
      if (h == 5 && v == 2)   chk("a_fb(5,2)", 32'(a_fb), 322);
    end
    chk("a_hsync low clocks line0", hs_low, 96);
    rst_a = 1'b1;

    // ---- Instance B: reset levels (active-high syncs idle low)
    check_b("b_rst");
    #3 rst_b = 1'b0;

    // Idle with en low; en raised only while pix_ce is low must not start
    for (int i = 0; i < 3; i++) cyc_b("b_idle", 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc_b("b_en_noce", 1'b0, 1'b1);

    // Two full frames plus wrap at full rate
    for (int i = 0; i < 2 * 98 + 1; i++) cyc_b("b_run", 1'b1, 1'b1);

    // One frame with pix_ce 1 in 4: outputs hold between steps
    for (int i = 0; i < 98; i++) begin
      for (int k = 0; k < 3; k++) cyc_b("b_stall", 1'b0, 1'b1);
      cyc_b("b_slow", 1'b1, 1'b1);
    end

    // Drop en mid-frame, re-raise it (no glitch), then drop until idle
    for (int i = 0; i < 200 && !(mv == 2 && mh == 3); i++) cyc_b("b_pre", 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc_b("b_drain", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc_b("b_rerun", 1'b1, 1'b1);
    for (int i = 0; i < 200 && m_st != 0; i++) cyc_b("b_drain2", 1'b1, 1'b0);
    chk("b_idle running", 32'(b_run), 0);
    chk("b_idle vsync", 32'(b_vs), 0);
    for (int i = 0; i < 3; i++) cyc_b("b_idle2", 1'b1, 1'b0);
    cyc_b("b_restart", 1'b1, 1'b1);
    chk("b_restart frame_start", 32'(b_fs), 1);

    // Asynchronous reset mid-frame, no clock edge in between
    for (int i = 0; i < 200 && !(mv == 3 && mh == 5); i++) cyc_b("b_pre_rst", 1'b1, 1'b1);
    #1 rst_b = 1'b1;
    #1;
    m_st = 0; mh = 0; mv = 0; mfb = 0;
    check_b("b_async_rst");
    @(posedge clk);
    #3 rst_b = 1'b0;
    cyc_b("b_after_rst", 1'b1, 1'b1);
    chk("b_after_rst frame_start", 32'(b_fs), 1);
    for (int i = 0; i < 20; i++) cyc_b("b_after_rst_run", 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
